// File: rtl/led_seq_driver.sv
// led_seq_driver
//   Upstream control stage for the 4-to-16 LED decoder. A three-state FSM
//   (IDLE / RUN / PAUSE) gates a prescaler; each time the prescaler wraps,
//   the LED index advances according to the pattern latched at start.
//
//   Optional feature macro: LED_SEQ_LFSR_EN
//     defined   -> mode 3 is a 4-bit Fibonacci LFSR sequence (x^4+x^3+1)
//     undefined -> no LFSR logic; mode 3 runs as an up sweep from 0
//                  (the mode output still reports 3)
//
// Parameters
//   DIV       clk cycles per index step (>= 2)
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   go        in   1  pulse: start from IDLE / resume from PAUSE
//   hold      in   1  pulse: RUN -> PAUSE
//   halt      in   1  pulse: any state -> IDLE (highest priority)
//   mode_sel  in   2  pattern: 0 up, 1 down, 2 ping-pong, 3 random
//   I         out  4  LED index to decoder
//   mode      out  2  pattern latched at start
//   start     out  1  high in RUN and PAUSE
//   idle      out  1  high in IDLE only
//   step      out  1  one-cycle pulse, coincident with each new index
module led_seq_driver #(
  parameter int DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       hold,
  input  logic       halt,
  input  logic [1:0] mode_sel,
  output logic [3:0] I,
  output logic [1:0] mode,
  output logic       start,
  output logic       idle,
  output logic       step
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_PP   = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [3:0]       i_q, i_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             start_q, start_d;
  logic             idle_q, idle_d;

  logic             launch;
  logic             counting;

  // Index loaded when a run starts. In random mode the index register itself
  // carries the LFSR state, so the start value doubles as the seed.
  function automatic logic [3:0] start_index(input logic [1:0] m);
    logic [3:0] v;
    v = 4'd0;
    if (m == MODE_DOWN) v = 4'd15;
`ifdef LED_SEQ_LFSR_EN
    if (m == 2'd3) v = 4'd1;
`endif
    return v;
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state (halt beats hold beats go)
  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (go)   state_d = S_RUN;
        S_RUN:   if (hold) state_d = S_PAUSE;
        S_PAUSE: if (go)   state_d = S_RUN;
        default:           state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs, computed from the next state so start/idle come out of flops
  always_comb begin
    start_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    idle_d  = (state_d == S_IDLE);
  end

  // The prescaler keeps counting on the edge that sees hold, so a pause
  // freezes it one count past where hold arrived; resume picks up from there.
  assign launch   = (state_q == S_IDLE) && go && !halt;
  assign counting = (state_q == S_RUN) && !halt;

  always_comb begin
    presc_d = presc_q;
    i_d     = i_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (halt) begin
      presc_d = '0;
      i_d     = 4'd0;
      dir_d   = DIR_UP;
    end else if (launch) begin
      presc_d = '0;
      mode_d  = mode_sel;
      dir_d   = DIR_UP;
      i_d     = start_index(mode_sel);
    end else if (counting) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        step_d  = 1'b1;
        case (mode_q)
          MODE_UP:   i_d = i_q + 4'd1;
          MODE_DOWN: i_d = i_q - 4'd1;
          MODE_PP: begin
            i_d = (dir_q == DIR_DOWN) ? (i_q - 4'd1) : (i_q + 4'd1);
            // Turn around on landing at an end so each end is shown once.
            if (i_d == 4'd15)     dir_d = DIR_DOWN;
            else if (i_d == 4'd0) dir_d = DIR_UP;
          end
          default: begin
`ifdef LED_SEQ_LFSR_EN
            // All-zero is the LFSR lock-up state; recover by reseeding.
            if (i_q == 4'd0) i_d = 4'd1;
            else             i_d = {i_q[2:0], i_q[3] ^ i_q[2]};
`else
            i_d = i_q + 4'd1;
`endif
          end
        endcase
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      i_q     <= 4'd0;
      mode_q  <= 2'd0;
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      start_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      presc_q <= presc_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      start_q <= start_d;
      idle_q  <= idle_d;
    end
  end

  assign I     = i_q;
  assign mode  = mode_q;
  assign start = start_q;
  assign idle  = idle_q;
  assign step  = step_q;

endmodule

// File: tb/tb_led_seq_driver.sv
// tb_led_seq_driver
//   Scoreboard bench for led_seq_driver with DIV=4. Stimulus pushes the
//   expected index and clock-edge number of every advance; a monitor pops one
//   entry per step pulse and compares value and timing.
module tb_led_seq_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       go = 1'b0;
  logic       hold = 1'b0;
  logic       halt = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [3:0] I;
  logic [1:0] mode;
  logic       start;
  logic       idle;
  logic       step;

  typedef struct {
    logic [3:0] val;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_tbl[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  led_seq_driver #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .hold(hold), .halt(halt),
    .mode_sel(mode_sel), .I(I), .mode(mode), .start(start), .idle(idle),
    .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every step pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && step === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 32'(I), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("step_index", 32'(I), 32'(e.val));
        check("step_cycle", cyc, e.cyc);
      end
    end
  end

  // Pulse go; g returns the edge number at which go was sampled.
  task automatic start_run(input logic [1:0] ms, output int g);
    @(negedge clk);
    mode_sel = ms;
    go = 1'b1;
    g = cyc + 1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic push_exp(input int v, input int c);
    exp_t e;
    e.val = 4'(v);
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic run_pattern(input string nm, input logic [1:0] ms, input int first_i);
    int g;
    int n;
    n = exp_tbl.size();
    start_run(ms, g);
    for (int j = 0; j < n; j++) push_exp(exp_tbl[j], g + DIV * (j + 1));
    check({nm, "_start"}, 32'(start), 1);
    check({nm, "_idle"}, 32'(idle), 0);
    check({nm, "_first_I"}, 32'(I), first_i);
    check({nm, "_mode"}, 32'(mode), 32'(ms));
    repeat (DIV * n) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check({nm, "_halt_I"}, 32'(I), 0);
    check({nm, "_halt_idle"}, 32'(idle), 1);
    check({nm, "_halt_start"}, 32'(start), 0);
    check({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int c;
    int bad;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_I", 32'(I), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_start", 32'(start), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_step", 32'(step), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_run_I", 32'(I), 0);

    // Up sweep through the 15 -> 0 wrap
    exp_tbl = {};
    for (int j = 1; j <= 17; j++) exp_tbl.push_back(j % 16);
    run_pattern("up", 2'd0, 0);

    // Down sweep through the 0 -> 15 wrap
    exp_tbl = {14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15};
    run_pattern("down", 2'd1, 15);

    // Ping-pong, two turnarounds
    exp_tbl = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
               14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    run_pattern("pingpong", 2'd2, 0);

    // Mode 3
`ifdef LED_SEQ_LFSR_EN
    exp_tbl = {2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    run_pattern("lfsr", 2'd3, 1);
`else
    exp_tbl = {1, 2, 3, 4, 5};
    run_pattern("mode3_up", 2'd3, 0);
`endif

    // Pause / resume / halt+go
    start_run(2'd0, g);
    push_exp(1, g + DIV);
    repeat (DIV) @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    hold = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (I !== 4'd1 || step !== 1'b0) bad++;
    end
    check("pause_frozen_cycles_bad", bad, 0);
    check("pause_start", 32'(start), 1);
    check("pause_idle", 32'(idle), 0);
    c = cyc;
    go = 1'b1;
    push_exp(2, c + 4);
    push_exp(3, c + 8);
    @(negedge clk);
    go = 1'b0;
    repeat (7) @(negedge clk);
    halt = 1'b1;
    go = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    go = 1'b0;
    check("halt_go_I", 32'(I), 0);
    check("halt_go_idle", 32'(idle), 1);
    check("halt_go_start", 32'(start), 0);
    repeat (8) @(negedge clk);
    check("halt_go_stays_I", 32'(I), 0);
    check("halt_go_stays_idle", 32'(idle), 1);
    check("pause_sb_empty", sb.size(), 0);

    // mode_sel ignored during RUN, then asynchronous reset mid-RUN
    start_run(2'd1, g);
    push_exp(14, g + DIV);
    repeat (2) @(negedge clk);
    mode_sel = 2'd2;
    repeat (4) @(negedge clk);
    check("mode_latched", 32'(mode), 1);
    check("run_I_before_rst", 32'(I), 14);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_I", 32'(I), 0);
    check("async_rst_start", 32'(start), 0);
    check("async_rst_idle", 32'(idle), 1);
    check("async_rst_mode", 32'(mode), 0);
    check("async_rst_step", 32'(step), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
